// File: rtl/rotary_button_interpret.sv
`default_nettype none
// ============================================================================
// Module  : rotary_button_interpret
// Purpose : Synchronise, debounce and decode a push-button quadrature encoder
//           into one-clock right / left / down event pulses.
// Revision: 1.0
// ============================================================================
module rotary_button_interpret #(
  parameter int ROT_DEBOUNCE = 50,
  parameter int BTN_DEBOUNCE = 5000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rotA,
  input  logic rotB,
  input  logic rotCenter,
  output logic right,
  output logic left,
  output logic down
);

  localparam int RW = (ROT_DEBOUNCE > 1) ? $clog2(ROT_DEBOUNCE) : 1;
  localparam int BW = (BTN_DEBOUNCE > 1) ? $clog2(BTN_DEBOUNCE) : 1;
  localparam logic [RW-1:0] c_ROT_LAST = RW'(ROT_DEBOUNCE - 1);
  localparam logic [BW-1:0] c_BTN_LAST = BW'(BTN_DEBOUNCE - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CW1      = 3'd1,
    ST_CCW1     = 3'd2,
    ST_CW_HALF  = 3'd3,
    ST_CCW_HALF = 3'd4
  } state_t;

  // Bit 1 carries phase A, bit 0 phase B, so vectors read as "AB".
  logic [1:0] w_ab_raw;
  logic [1:0] r_ab_meta;
  logic [1:0] r_ab_sync;
  logic [1:0] w_ab_filt;

  assign w_ab_raw = {rotA, rotB};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ab_meta <= 2'b00;
      r_ab_sync <= 2'b00;
    end else begin
      r_ab_meta <= w_ab_raw;
      r_ab_sync <= r_ab_meta;
    end
  end

  generate
    for (genvar i = 0; i < 2; i++) begin : g_rot_db
      logic [RW-1:0] r_cnt;
      logic          r_filt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt  <= '0;
          r_filt <= 1'b0;
        end else if (r_ab_sync[i] == r_filt) begin
          r_cnt  <= '0;
        end else if (r_cnt == c_ROT_LAST) begin
          r_filt <= r_ab_sync[i];
          r_cnt  <= '0;
        end else begin
          r_cnt  <= r_cnt + RW'(1);
        end
      end

      assign w_ab_filt[i] = r_filt;
    end
  endgenerate

  // The decoder only arms once AB has been settled at 00, so an encoder left
  // mid-detent across a reset cannot produce a spurious pulse.
  logic          w_ab_quiet;
  logic [RW-1:0] r_settle;
  logic          r_armed;

  assign w_ab_quiet = (r_ab_sync == 2'b00) && (w_ab_filt == 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle <= '0;
      r_armed  <= 1'b0;
    end else if (!w_ab_quiet) begin
      r_settle <= '0;
    end else if (!r_armed) begin
      if (r_settle == c_ROT_LAST) begin
        r_armed <= 1'b1;
      end else begin
        r_settle <= r_settle + RW'(1);
      end
    end
  end

  state_t r_state;
  state_t w_state_nxt;
  logic   w_right_nxt;
  logic   w_left_nxt;
  logic   r_right;
  logic   r_left;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_right <= 1'b0;
      r_left  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_right <= w_right_nxt;
      r_left  <= w_left_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_right_nxt = 1'b0;
    w_left_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_armed) begin
          if (w_ab_filt == 2'b10) begin
            w_state_nxt = ST_CW1;
          end else if (w_ab_filt == 2'b01) begin
            w_state_nxt = ST_CCW1;
          end
        end
      end
      ST_CW1: begin
        if (w_ab_filt == 2'b11) begin
          w_state_nxt = ST_CW_HALF;
          w_right_nxt = 1'b1;
        end else if (w_ab_filt == 2'b00) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CCW1: begin
        if (w_ab_filt == 2'b11) begin
          w_state_nxt = ST_CCW_HALF;
          w_left_nxt  = 1'b1;
        end else if (w_ab_filt == 2'b00) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CW_HALF, ST_CCW_HALF: begin
        if (w_ab_filt == 2'b00) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  logic          r_btn_meta;
  logic          r_btn_sync;
  logic          r_btn_filt;
  logic          r_btn_prev;
  logic [BW-1:0] r_btn_cnt;
  logic          r_down;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_meta <= 1'b0;
      r_btn_sync <= 1'b0;
      r_btn_filt <= 1'b0;
      r_btn_cnt  <= '0;
      r_btn_prev <= 1'b0;
      r_down     <= 1'b0;
    end else begin
      r_btn_meta <= rotCenter;
      r_btn_sync <= r_btn_meta;
      r_btn_prev <= r_btn_filt;
      r_down     <= r_btn_filt & ~r_btn_prev;
      if (r_btn_sync == r_btn_filt) begin
        r_btn_cnt  <= '0;
      end else if (r_btn_cnt == c_BTN_LAST) begin
        r_btn_filt <= r_btn_sync;
        r_btn_cnt  <= '0;
      end else begin
        r_btn_cnt  <= r_btn_cnt + BW'(1);
      end
    end
  end

  assign right = r_right;
  assign left  = r_left;
  assign down  = r_down;

endmodule
`default_nettype wire

// File: tb/tb_rotary_button_interpret.sv
`default_nettype none
// ============================================================================
// Module  : tb_rotary_button_interpret
// Purpose : Directed self-checking bench for rotary_button_interpret.
// Revision: 1.0
// ============================================================================
module tb_rotary_button_interpret;

  logic clk;
  logic rst_n;
  logic rotA;
  logic rotB;
  logic rotCenter;
  logic right;
  logic left;
  logic down;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_right  = 0;
  int n_left   = 0;
  int n_down   = 0;
  int n_both   = 0;
  int t_right  = 0;
  int t_left   = 0;
  int t_down   = 0;

  rotary_button_interpret #(
    .ROT_DEBOUNCE(50),
    .BTN_DEBOUNCE(5000)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rotA     (rotA),
    .rotB     (rotB),
    .rotCenter(rotCenter),
    .right    (right),
    .left     (left),
    .down     (down)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (right === 1'b1) begin n_right++; t_right = cyc; end
    if (left  === 1'b1) begin n_left++;  t_left  = cyc; end
    if (down  === 1'b1) begin n_down++;  t_down  = cyc; end
    if (right === 1'b1 && left === 1'b1) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Full detent: leading phase, lagging phase, leading falls, lagging falls.
  task automatic do_turn(input bit cw, output int t_second);
    @(negedge clk);
    if (cw) rotA = 1'b1; else rotB = 1'b1;
    wait_cyc(75);
    if (cw) rotB = 1'b1; else rotA = 1'b1;
    t_second = cyc;
    wait_cyc(75);
    if (cw) rotA = 1'b0; else rotB = 1'b0;
    wait_cyc(75);
    if (cw) rotB = 1'b0; else rotA = 1'b0;
    wait_cyc(100);
  endtask

  initial begin
    int r0, l0, d0, t2, lat;
    rst_n = 1'b0; rotA = 1'b0; rotB = 1'b0; rotCenter = 1'b0;
    wait_cyc(3);
    check("rst_right", {31'd0, right}, 0);
    check("rst_left",  {31'd0, left},  0);
    check("rst_down",  {31'd0, down},  0);
    rst_n = 1'b1;
    wait_cyc(100);
    check("idle_right", n_right, 0);
    check("idle_left",  n_left,  0);
    check("idle_down",  n_down,  0);

    r0 = n_right; l0 = n_left;
    do_turn(1'b1, t2);
    check("cw_right_cnt", n_right - r0, 1);
    check("cw_left_cnt",  n_left - l0,  0);
    lat = t_right - t2;
    check("cw_latency", {31'd0, (lat >= 50 && lat <= 56)}, 1);

    r0 = n_right; l0 = n_left;
    do_turn(1'b0, t2);
    check("ccw_left_cnt",  n_left - l0,  1);
    check("ccw_right_cnt", n_right - r0, 0);
    lat = t_left - t2;
    check("ccw_latency", {31'd0, (lat >= 50 && lat <= 56)}, 1);

    d0 = n_down;
    @(negedge clk);
    rotCenter = 1'b1;
    t2 = cyc;
    wait_cyc(6250);
    check("press_down_cnt", n_down - d0, 1);
    lat = t_down - t2;
    check("press_latency", {31'd0, (lat >= 5000 && lat <= 5006)}, 1);
    rotCenter = 1'b0;
    wait_cyc(5100);
    check("release_down_cnt", n_down - d0, 1);

    r0 = n_right; l0 = n_left; d0 = n_down;
    for (int k = 0; k < 5; k++) begin
      rotA = 1'b1; wait_cyc(20); rotA = 1'b0; wait_cyc(30);
      rotB = 1'b1; wait_cyc(20); rotB = 1'b0; wait_cyc(30);
      rotCenter = 1'b1; wait_cyc(20); rotCenter = 1'b0; wait_cyc(30);
    end
    wait_cyc(200);
    check("glitch_right", n_right - r0, 0);
    check("glitch_left",  n_left - l0,  0);
    check("glitch_down",  n_down - d0,  0);

    r0 = n_right; l0 = n_left;
    rotA = 1'b1; wait_cyc(75); rotA = 1'b0; wait_cyc(100);
    check("abandon_right", n_right - r0, 0);
    check("abandon_left",  n_left - l0,  0);

    // Reset while in CW1 with A still held, then complete the half-turn.
    rotA = 1'b1; wait_cyc(75);
    rst_n = 1'b0;
    wait_cyc(3);
    check("midrst_right", {31'd0, right}, 0);
    check("midrst_left",  {31'd0, left},  0);
    rst_n = 1'b1;
    wait_cyc(100);
    rotB = 1'b1; wait_cyc(100);
    check("postrst_right", n_right - r0, 0);
    check("postrst_left",  n_left - l0,  0);
    rotA = 1'b0; rotB = 1'b0;
    wait_cyc(150);
    do_turn(1'b1, t2);
    check("rearm_right", n_right - r0, 1);
    check("never_both", n_both, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
